axi_m_if: RTL and testbench

- AXI4 master (initiator) port that turns a simple CPU-side memory request into one AXI INCR burst.
- Sits between a CPU/cache core and a crossbar slave port.
- Handles one outstanding transaction at a time: read (AR→R) or write (AW→W→B).
- Reports completion and the merged response to the CPU side.

---
 rtl/axi_pkg.sv | 34 +++
 rtl/axi_m_if.sv | 195 +++++++++++++++++++
 tb/tb_axi_m_if.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 constants, encodings and the master-port FSM state type.
package axi_pkg;

    localparam int AXI_ID_BITS   = 4;
    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_STRB_BITS = AXI_DATA_BITS / 8;
    localparam int AXI_LEN_BITS  = 4;
    localparam int AXI_SIZE_BITS = 3;

    // Burst type encodings
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Response encodings
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Every beat is a full 32-bit word
    localparam logic [AXI_SIZE_BITS-1:0] SIZE_4B = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5
    } axi_state_e;

endpackage

// File: rtl/axi_m_if.sv
// AXI4 master port: turns one CPU memory request into a single INCR burst,
// one transaction outstanding, and reports a merged response on DONE_o.
module axi_m_if
    import axi_pkg::*;
#(
    parameter logic [3:0] MASTER_ID = 4'd0,
    parameter int ID_BITS   = AXI_ID_BITS,
    parameter int ADDR_BITS = AXI_ADDR_BITS,
    parameter int DATA_BITS = AXI_DATA_BITS
) (
    input  logic                   AXI_CLK_i,
    input  logic                   AXI_RST_i,
    // CPU side
    input  logic                   REQ_VALID_i,
    output logic                   REQ_READY_o,
    input  logic                   REQ_WRITE_i,
    input  logic [ADDR_BITS-1:0]   REQ_ADDR_i,
    input  logic [3:0]             REQ_LEN_i,
    input  logic [DATA_BITS-1:0]   WDATA_i,
    input  logic [DATA_BITS/8-1:0] WSTRB_i,
    input  logic                   WDATA_VALID_i,
    output logic                   WDATA_READY_o,
    output logic [DATA_BITS-1:0]   RDATA_o,
    output logic                   RDATA_VALID_o,
    output logic                   RDATA_LAST_o,
    output logic                   DONE_o,
    output logic [1:0]             RESP_o,
    // AR channel
    output logic [ID_BITS-1:0]     ARID_o,
    output logic [ADDR_BITS-1:0]   ARADDR_o,
    output logic [3:0]             ARLEN_o,
    output logic [2:0]             ARSIZE_o,
    output logic [1:0]             ARBURST_o,
    output logic                   ARVALID_o,
    input  logic                   ARREADY_i,
    // R channel
    input  logic [ID_BITS-1:0]     RID_i,
    input  logic [DATA_BITS-1:0]   RDATA_i,
    input  logic [1:0]             RRESP_i,
    input  logic                   RLAST_i,
    input  logic                   RVALID_i,
    output logic                   RREADY_o,
    // AW channel
    output logic [ID_BITS-1:0]     AWID_o,
    output logic [ADDR_BITS-1:0]   AWADDR_o,
    output logic [3:0]             AWLEN_o,
    output logic [2:0]             AWSIZE_o,
    output logic [1:0]             AWBURST_o,
    output logic                   AWVALID_o,
    input  logic                   AWREADY_i,
    // W channel
    output logic [DATA_BITS-1:0]   WDATA_o,
    output logic [DATA_BITS/8-1:0] WSTRB_o,
    output logic                   WLAST_o,
    output logic                   WVALID_o,
    input  logic                   WREADY_i,
    // B channel
    input  logic [ID_BITS-1:0]     BID_i,
    input  logic [1:0]             BRESP_i,
    input  logic                   BVALID_i,
    output logic                   BREADY_o
);

    axi_state_e state, state_nxt;

    logic [ADDR_BITS-1:0] addr_q;
    logic [3:0]           len_q;
    logic [3:0]           cnt_q;
    logic                 err_q;
    logic [1:0]           err_code_q;
    logic                 done_q;
    logic [1:0]           resp_q;

    logic                 req_hs, r_beat, w_hs, b_hs, at_last;
    logic                 beat_err;
    logic [1:0]           beat_code;

    assign req_hs  = (state == ST_IDLE) && REQ_VALID_i;
    assign r_beat  = (state == ST_R) && RVALID_i;
    assign w_hs    = (state == ST_W) && WDATA_VALID_i && WREADY_i;
    assign b_hs    = (state == ST_B) && BVALID_i;
    assign at_last = (cnt_q == len_q);

    // Address channel payload comes straight from the latched request
    assign ARID_o    = ID_BITS'(MASTER_ID);
    assign ARADDR_o  = addr_q;
    assign ARLEN_o   = len_q;
    assign ARSIZE_o  = SIZE_4B;
    assign ARBURST_o = BURST_INCR;
    assign AWID_o    = ID_BITS'(MASTER_ID);
    assign AWADDR_o  = addr_q;
    assign AWLEN_o   = len_q;
    assign AWSIZE_o  = SIZE_4B;
    assign AWBURST_o = BURST_INCR;
    assign DONE_o    = done_q;
    assign RESP_o    = resp_q;

    // State register
    always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
        if (!AXI_RST_i) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (REQ_VALID_i) state_nxt = REQ_WRITE_i ? ST_AW : ST_AR;
            ST_AR:   if (ARREADY_i) state_nxt = ST_R;
            ST_R:    if (r_beat && RLAST_i) state_nxt = ST_IDLE;
            ST_AW:   if (AWREADY_i) state_nxt = ST_W;
            ST_W:    if (w_hs && at_last) state_nxt = ST_B;
            ST_B:    if (BVALID_i) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state; data passes through
    always_comb begin
        REQ_READY_o   = (state == ST_IDLE);
        ARVALID_o     = (state == ST_AR);
        AWVALID_o     = (state == ST_AW);
        RREADY_o      = (state == ST_R);
        BREADY_o      = (state == ST_B);
        RDATA_o       = RDATA_i;
        RDATA_VALID_o = r_beat;
        RDATA_LAST_o  = r_beat && RLAST_i;
        WDATA_o       = WDATA_i;
        WSTRB_o       = WSTRB_i;
        WVALID_o      = (state == ST_W) && WDATA_VALID_i;
        WDATA_READY_o = (state == ST_W) && WREADY_i;
        WLAST_o       = (state == ST_W) && at_last;
    end

    // Classify the current R/B beat; a slave response code outranks ID/length faults
    always_comb begin
        beat_err  = 1'b0;
        beat_code = RESP_OKAY;
        if (r_beat) begin
            if (RRESP_i != RESP_OKAY) begin
                beat_err  = 1'b1;
                beat_code = RRESP_i;
            end else if ((RID_i != ID_BITS'(MASTER_ID)) || (RLAST_i != at_last)) begin
                beat_err  = 1'b1;
                beat_code = RESP_SLVERR;
            end
        end else if (b_hs) begin
            if (BRESP_i != RESP_OKAY) begin
                beat_err  = 1'b1;
                beat_code = BRESP_i;
            end else if (BID_i != ID_BITS'(MASTER_ID)) begin
                beat_err  = 1'b1;
                beat_code = RESP_SLVERR;
            end
        end
    end

    // Request latch, beat counter and sticky first-error capture
    always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
        if (!AXI_RST_i) begin
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= RESP_OKAY;
        end else begin
            if (req_hs) begin
                addr_q     <= REQ_ADDR_i;
                len_q      <= REQ_LEN_i;
                cnt_q      <= '0;
                err_q      <= 1'b0;
                err_code_q <= RESP_OKAY;
            end
            if (r_beat) cnt_q <= RLAST_i ? 4'd0 : cnt_q + 4'd1;
            if (w_hs)   cnt_q <= at_last ? 4'd0 : cnt_q + 4'd1;
            if (beat_err && !err_q) begin
                err_q      <= 1'b1;
                err_code_q <= beat_code;
            end
        end
    end

    // Completion pulse and merged response, one cycle after the final beat
    always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
        if (!AXI_RST_i) begin
            done_q <= 1'b0;
            resp_q <= RESP_OKAY;
        end else begin
            done_q <= (r_beat && RLAST_i) || b_hs;
            if ((r_beat && RLAST_i) || b_hs)
                resp_q <= err_q ? err_code_q : (beat_err ? beat_code : RESP_OKAY);
        end
    end

endmodule

// File: tb/tb_axi_m_if.sv
// Scoreboard bench for axi_m_if: a driver issues CPU requests and pushes the
// expected AXI/CPU-side results, a slave model answers on AR/R/AW/W/B, and a
// monitor compares every DUT output event against the queues.
module tb_axi_m_if;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        REQ_VALID_i = 0, REQ_WRITE_i = 0;
    logic [31:0] REQ_ADDR_i = '0;
    logic [3:0]  REQ_LEN_i = '0;
    logic [31:0] WDATA_i = '0;
    logic [3:0]  WSTRB_i = '0;
    logic        WDATA_VALID_i = 0;
    logic        ARREADY_i = 0, AWREADY_i = 0, WREADY_i = 0;
    logic [3:0]  RID_i = '0, BID_i = '0;
    logic [31:0] RDATA_i = '0;
    logic [1:0]  RRESP_i = '0, BRESP_i = '0;
    logic        RLAST_i = 0, RVALID_i = 0, BVALID_i = 0;

    logic        REQ_READY_o, WDATA_READY_o, RDATA_VALID_o, RDATA_LAST_o, DONE_o;
    logic [31:0] RDATA_o, ARADDR_o, AWADDR_o, WDATA_o;
    logic [1:0]  RESP_o, ARBURST_o, AWBURST_o;
    logic [3:0]  ARID_o, ARLEN_o, AWID_o, AWLEN_o, WSTRB_o;
    logic [2:0]  ARSIZE_o, AWSIZE_o;
    logic        ARVALID_o, AWVALID_o, RREADY_o, WLAST_o, WVALID_o, BREADY_o;

    always #5 clk = ~clk;

    axi_m_if dut (
        .AXI_CLK_i(clk), .AXI_RST_i(rst_n),
        .REQ_VALID_i(REQ_VALID_i), .REQ_READY_o(REQ_READY_o), .REQ_WRITE_i(REQ_WRITE_i),
        .REQ_ADDR_i(REQ_ADDR_i), .REQ_LEN_i(REQ_LEN_i),
        .WDATA_i(WDATA_i), .WSTRB_i(WSTRB_i), .WDATA_VALID_i(WDATA_VALID_i),
        .WDATA_READY_o(WDATA_READY_o),
        .RDATA_o(RDATA_o), .RDATA_VALID_o(RDATA_VALID_o), .RDATA_LAST_o(RDATA_LAST_o),
        .DONE_o(DONE_o), .RESP_o(RESP_o),
        .ARID_o(ARID_o), .ARADDR_o(ARADDR_o), .ARLEN_o(ARLEN_o), .ARSIZE_o(ARSIZE_o),
        .ARBURST_o(ARBURST_o), .ARVALID_o(ARVALID_o), .ARREADY_i(ARREADY_i),
        .RID_i(RID_i), .RDATA_i(RDATA_i), .RRESP_i(RRESP_i), .RLAST_i(RLAST_i),
        .RVALID_i(RVALID_i), .RREADY_o(RREADY_o),
        .AWID_o(AWID_o), .AWADDR_o(AWADDR_o), .AWLEN_o(AWLEN_o), .AWSIZE_o(AWSIZE_o),
        .AWBURST_o(AWBURST_o), .AWVALID_o(AWVALID_o), .AWREADY_i(AWREADY_i),
        .WDATA_o(WDATA_o), .WSTRB_o(WSTRB_o), .WLAST_o(WLAST_o), .WVALID_o(WVALID_o),
        .WREADY_i(WREADY_i),
        .BID_i(BID_i), .BRESP_i(BRESP_i), .BVALID_i(BVALID_i), .BREADY_o(BREADY_o)
    );

    // One transaction as seen by both the CPU driver and the slave model
    typedef struct packed {
        logic              wr;
        logic [31:0]       addr;
        logic [3:0]        len;
        logic [1:0]        ar_dly;
        logic [15:0][31:0] data;
        logic [15:0][1:0]  rresp;
        logic [15:0][3:0]  rid;
        logic [15:0]       rlast;
        logic [15:0][3:0]  wstrb;
        logic [1:0]        bresp;
        logic [3:0]        bid;
    } txn_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  len;
    } areq_t;

    txn_t        plan_q[$];
    areq_t       exp_a_q[$];
    logic [32:0] exp_r_q[$];   // {last, data}
    logic [36:0] exp_w_q[$];   // {last, strb, data}
    logic [1:0]  exp_d_q[$];

    int tests = 0;
    int fails = 0;
    bit mon_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic txn_t mk(input logic wr, input logic [31:0] addr, input logic [3:0] len);
        txn_t t;
        t = '0;
        t.wr = wr;
        t.addr = addr;
        t.len = len;
        t.ar_dly = 2'($urandom_range(0, 3));
        for (int i = 0; i < 16; i++) begin
            t.data[i]  = $urandom;
            t.wstrb[i] = 4'($urandom);
        end
        t.rlast[len] = 1'b1;
        return t;
    endfunction

    // Push expectations derived from the protocol rules, then present the request
    task automatic issue(input txn_t t);
        logic [1:0] er;
        bit bad;
        int n, idx;
        bit hs;
        plan_q.push_back(t);
        exp_a_q.push_back({t.wr, t.addr, t.len});
        er = RESP_OKAY;
        bad = 0;
        if (!t.wr) begin
            for (int i = 0; i < 16; i++) begin
                exp_r_q.push_back({t.rlast[i], t.data[i]});
                if (!bad) begin
                    if (t.rresp[i] != RESP_OKAY) begin er = t.rresp[i]; bad = 1; end
                    else if (t.rid[i] != 4'd0 || t.rlast[i] != (i == int'(t.len))) begin
                        er = RESP_SLVERR; bad = 1;
                    end
                end
                if (t.rlast[i]) break;
            end
        end else begin
            for (int i = 0; i <= int'(t.len); i++)
                exp_w_q.push_back({(i == int'(t.len)), t.wstrb[i], t.data[i]});
            if (t.bresp != RESP_OKAY) er = t.bresp;
            else if (t.bid != 4'd0) er = RESP_SLVERR;
        end
        exp_d_q.push_back(er);

        REQ_VALID_i = 1; REQ_WRITE_i = t.wr; REQ_ADDR_i = t.addr; REQ_LEN_i = t.len;
        n = 0;
        do begin @(negedge clk); n++; end while (!REQ_READY_o && n < 2000);
        if (n >= 2000) chk("req_accept_timeout", 64'(n), 64'(0));
        @(posedge clk); #1;
        REQ_VALID_i = 0;
        if (t.wr) begin
            idx = 0; n = 0;
            while (idx <= int'(t.len) && n < 2000) begin
                WDATA_VALID_i = ($urandom_range(0, 3) != 0);
                WDATA_i = t.data[idx];
                WSTRB_i = t.wstrb[idx];
                @(negedge clk);
                hs = WDATA_VALID_i && WDATA_READY_o;
                @(posedge clk); #1;
                if (hs) idx++;
                n++;
            end
            if (n >= 2000) chk("wbeat_timeout", 64'(idx), 64'(t.len) + 1);
            WDATA_VALID_i = 0;
        end
    endtask

    // Slave model: answers whatever address request the DUT raises
    task automatic slave_run();
        txn_t p;
        int n, k;
        bit hs;
        forever begin
            @(negedge clk);
            if (ARVALID_o || AWVALID_o) begin
                if (plan_q.size() == 0) begin
                    chk("unplanned_addr_req", 64'(1), 64'(0));
                    continue;
                end
                p = plan_q.pop_front();
                @(posedge clk); #1;
                repeat (int'(p.ar_dly)) begin @(posedge clk); #1; end
                if (!p.wr) begin
                    ARREADY_i = 1; @(posedge clk); #1; ARREADY_i = 0;
                    for (int i = 0; i < 16; i++) begin
                        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                        RVALID_i = 1; RDATA_i = p.data[i]; RRESP_i = p.rresp[i];
                        RID_i = p.rid[i]; RLAST_i = p.rlast[i];
                        @(posedge clk); #1;
                        RVALID_i = 0; RLAST_i = 0;
                        if (p.rlast[i]) break;
                    end
                end else begin
                    AWREADY_i = 1; @(posedge clk); #1; AWREADY_i = 0;
                    n = 0; k = 0;
                    while (n <= int'(p.len) && k < 2000) begin
                        WREADY_i = 1'($urandom_range(0, 1));
                        @(negedge clk);
                        hs = WVALID_o && WREADY_i;
                        @(posedge clk); #1;
                        if (hs) n++;
                        k++;
                    end
                    WREADY_i = 0;
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    BVALID_i = 1; BRESP_i = p.bresp; BID_i = p.bid;
                    @(posedge clk); #1;
                    BVALID_i = 0;
                end
            end
        end
    endtask

    // Monitor: compare every observable DUT event against the scoreboard
    areq_t       ma;
    logic [32:0] mr;
    logic [36:0] mw;
    logic [1:0]  md;
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (ARVALID_o) begin
                if (exp_a_q.size() == 0) chk("ar_unexpected", 64'(1), 64'(0));
                else begin
                    ma = exp_a_q[0];
                    chk("ar_is_read", 64'(ma.wr), 64'(0));
                    chk("araddr", 64'(ARADDR_o), 64'(ma.addr));
                    chk("arlen", 64'(ARLEN_o), 64'(ma.len));
                    chk("arsize_burst_id", {ARSIZE_o, ARBURST_o, ARID_o}, {3'b010, 2'b01, 4'd0});
                    if (ARREADY_i) void'(exp_a_q.pop_front());
                end
            end
            if (AWVALID_o) begin
                if (exp_a_q.size() == 0) chk("aw_unexpected", 64'(1), 64'(0));
                else begin
                    ma = exp_a_q[0];
                    chk("aw_is_write", 64'(ma.wr), 64'(1));
                    chk("awaddr", 64'(AWADDR_o), 64'(ma.addr));
                    chk("awlen", 64'(AWLEN_o), 64'(ma.len));
                    chk("awsize_burst_id", {AWSIZE_o, AWBURST_o, AWID_o}, {3'b010, 2'b01, 4'd0});
                    if (AWREADY_i) void'(exp_a_q.pop_front());
                end
            end
            if (RDATA_VALID_o) begin
                if (exp_r_q.size() == 0) chk("rbeat_unexpected", 64'(1), 64'(0));
                else begin
                    mr = exp_r_q.pop_front();
                    chk("rdata_last", {RDATA_LAST_o, RDATA_o}, 64'(mr));
                end
            end
            if (WVALID_o && WREADY_i) begin
                if (exp_w_q.size() == 0) chk("wbeat_unexpected", 64'(1), 64'(0));
                else begin
                    mw = exp_w_q.pop_front();
                    chk("wlast_strb_data", {WLAST_o, WSTRB_o, WDATA_o}, 64'(mw));
                end
            end
            if (DONE_o) begin
                if (exp_d_q.size() == 0) chk("done_unexpected", 64'(1), 64'(0));
                else begin
                    md = exp_d_q.pop_front();
                    chk("resp", 64'(RESP_o), 64'(md));
                    chk("req_ready_in_done", 64'(REQ_READY_o), 64'(1));
                end
            end
        end
    end

    // Hard stop if anything hangs
    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        int n;
        // Reset asserts asynchronously between edges
        #1 rst_n = 0;
        #2;
        chk("rst_req_ready", 64'(REQ_READY_o), 64'(1));
        chk("rst_valids", {ARVALID_o, AWVALID_o, WVALID_o, RDATA_VALID_o},  64'(0));
        chk("rst_readies", {RREADY_o, BREADY_o, WDATA_READY_o}, 64'(0));
        chk("rst_done_resp", {DONE_o, RESP_o}, 64'(0));
        chk("rst_addr_len", {ARADDR_o, ARLEN_o}, 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Reset in the middle of a write burst
        @(posedge clk); #1;
        REQ_VALID_i = 1; REQ_WRITE_i = 1; REQ_ADDR_i = 32'h3000; REQ_LEN_i = 4'd3;
        @(posedge clk); #1;
        REQ_VALID_i = 0;
        chk("mid_aw_valid", 64'(AWVALID_o), 64'(1));
        AWREADY_i = 1;
        @(posedge clk); #1;
        AWREADY_i = 0; WDATA_VALID_i = 1; WDATA_i = 32'hCAFE0000; WREADY_i = 1;
        chk("mid_w_beat0_wlast", 64'(WLAST_o), 64'(0));
        @(posedge clk); #1;
        chk("mid_w_beat1_wvalid", 64'(WVALID_o), 64'(1));
        #2 rst_n = 0;
        #1;
        chk("async_rst_wvalid", 64'(WVALID_o), 64'(0));
        chk("async_rst_done", 64'(DONE_o), 64'(0));
        chk("async_rst_req_ready", 64'(REQ_READY_o), 64'(1));
        WDATA_VALID_i = 0; WREADY_i = 0;
        @(posedge clk); #1 rst_n = 1;
        chk("post_rst_req_ready", 64'(REQ_READY_o), 64'(1));

        mon_en = 1;
        fork
            slave_run();
            begin
                // Read len 3 with a delayed ARREADY
                t = mk(0, 32'h0000_1000, 4'd3); t.ar_dly = 2'd2; issue(t);
                // Write len 1, gapped CPU beats and toggling WREADY
                t = mk(1, 32'h0000_2000, 4'd1); issue(t);
                // Beat 2 of 4 returns DECERR
                t = mk(0, 32'h0000_1100, 4'd3); t.rresp[1] = 2'b11; issue(t);
                // Early RLAST on beat 2 of 4
                t = mk(0, 32'h0000_1200, 4'd3); t.rlast[3] = 0; t.rlast[1] = 1; issue(t);
                // Write answered with a foreign BID
                t = mk(1, 32'h0000_2100, 4'd2); t.bid = 4'h5; issue(t);
                // Back-to-back single-beat read then write
                t = mk(0, 32'h0000_1300, 4'd0); issue(t);
                t = mk(1, 32'h0000_2200, 4'd0); issue(t);
                // Maximum length burst
                t = mk(0, 32'h0000_4000, 4'd15); issue(t);
                // Randomized mix
                for (int j = 0; j < 30; j++) begin
                    t = mk(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                           4'($urandom_range(0, 15)));
                    if (!t.wr) begin
                        for (int i = 0; i < 16; i++) begin
                            if ($urandom_range(0, 15) == 0) t.rresp[i] = 2'($urandom_range(1, 3));
                            if ($urandom_range(0, 19) == 0) t.rid[i] = 4'($urandom_range(1, 15));
                        end
                        if ($urandom_range(0, 7) == 0) begin
                            t.rlast[t.len] = 0;
                            t.rlast[$urandom_range(0, int'(t.len))] = 1;
                        end
                    end else begin
                        if ($urandom_range(0, 5) == 0) t.bresp = 2'($urandom_range(1, 3));
                        if ($urandom_range(0, 7) == 0) t.bid = 4'($urandom_range(1, 15));
                    end
                    issue(t);
                end
                n = 0;
                while ((exp_d_q.size() + exp_r_q.size() + exp_w_q.size() + exp_a_q.size()) != 0
                       && n < 5000) begin
                    @(negedge clk);
                    n++;
                end
                chk("scoreboard_drained",
                    64'(exp_d_q.size() + exp_r_q.size() + exp_w_q.size() + exp_a_q.size()), 64'(0));
                repeat (3) @(posedge clk);
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        join
    end

endmodule
